mem_arbiter: RTL

Arbitrates one single-port synchronous RAM between three requesters:
- video fetch (read-only)
- 6502 bus interface (read/write)
- DMA/loader port (read/write)

It sits between address_decode/cpu, the vdp text fetcher and the RAM macro. It replaces the dual-port arrangement so the design can use a single-port RAM. Priority is fixed, with starvation override so neither the CPU nor DMA can be locked out by continuous video fetch.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port synchronous RAM between video, cpu and dma,
// with starvation promotion for cpu/dma. Optional grant statistics under `MEM_ARB_STATS_EN`.
module mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock_50,
  input  logic          res,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_adr,
  output logic          vid_ack,
  output logic          vid_rvld,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdat,
  output logic          cpu_ack,
  output logic          cpu_rvld,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wdat,
  output logic          dma_ack,
  output logic          dma_rvld,
  output logic [DW-1:0] rd_dat,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_wdat,
  input  logic [DW-1:0] ram_rdat
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic [1:0]    stat_sel,
  output logic [15:0]   stat_cnt
`endif
);

  typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_CPU, SRC_DMA} src_t;

  logic [3:0]    cpu_wait, dma_wait;
  logic          cpu_starved, dma_starved;
  src_t          gnt, tag_in;
  src_t          tag_q [RAM_LAT+1];
  logic          gnt_we;
  logic [AW-1:0] gnt_adr;
  logic [DW-1:0] gnt_wdat;

  assign cpu_starved = (cpu_wait >= 4'(STARVE_MAX));
  assign dma_starved = (dma_wait >= 4'(STARVE_MAX));

  always_comb begin
    gnt = SRC_NONE;
    if (!res) begin
      if (cpu_req && cpu_starved)      gnt = SRC_CPU;
      else if (dma_req && dma_starved) gnt = SRC_DMA;
      else if (vid_req)                gnt = SRC_VID;
      else if (cpu_req)                gnt = SRC_CPU;
      else if (dma_req)                gnt = SRC_DMA;
    end
  end

  assign vid_ack = (gnt == SRC_VID);
  assign cpu_ack = (gnt == SRC_CPU);
  assign dma_ack = (gnt == SRC_DMA);

  // A denied requester keeps counting up to 15; a losing starved dma stays saturated-high.
  always_ff @(posedge clock_50) begin
    if (res) begin
      cpu_wait <= '0;
      dma_wait <= '0;
    end else begin
      if (cpu_req && !cpu_ack) begin
        if (cpu_wait != 4'hF) cpu_wait <= cpu_wait + 4'd1;
      end else begin
        cpu_wait <= '0;
      end
      if (dma_req && !dma_ack) begin
        if (dma_wait != 4'hF) dma_wait <= dma_wait + 4'd1;
      end else begin
        dma_wait <= '0;
      end
    end
  end

  always_comb begin
    gnt_we   = 1'b0;
    gnt_adr  = ram_adr;
    gnt_wdat = ram_wdat;
    case (gnt)
      SRC_VID: gnt_adr = vid_adr;
      SRC_CPU: begin
        gnt_we   = cpu_we;
        gnt_adr  = cpu_adr;
        gnt_wdat = cpu_wdat;
      end
      SRC_DMA: begin
        gnt_we   = dma_we;
        gnt_adr  = dma_adr;
        gnt_wdat = dma_wdat;
      end
      default: ;
    endcase
    tag_in = (gnt != SRC_NONE && !gnt_we) ? gnt : SRC_NONE;
  end

  always_ff @(posedge clock_50) begin
    if (res) begin
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_adr  <= '0;
      ram_wdat <= '0;
    end else begin
      ram_en <= (gnt != SRC_NONE);
      ram_we <= gnt_we;
      if (gnt != SRC_NONE) begin
        ram_adr  <= gnt_adr;
        ram_wdat <= gnt_wdat;
      end
    end
  end

  // Stage RAM_LAT lines up with ram_rdat for the read issued RAM_LAT+1 cycles earlier.
  always_ff @(posedge clock_50) begin
    if (res) begin
      for (int i = 0; i <= RAM_LAT; i++) tag_q[i] <= SRC_NONE;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i <= RAM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clock_50) begin
    if (res) begin
      rd_dat   <= '0;
      vid_rvld <= 1'b0;
      cpu_rvld <= 1'b0;
      dma_rvld <= 1'b0;
    end else begin
      vid_rvld <= (tag_q[RAM_LAT] == SRC_VID);
      cpu_rvld <= (tag_q[RAM_LAT] == SRC_CPU);
      dma_rvld <= (tag_q[RAM_LAT] == SRC_DMA);
      if (tag_q[RAM_LAT] != SRC_NONE) rd_dat <= ram_rdat;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_q [4];
  logic        forced_gnt;

  // Only the starved rule can take the slot away from an active video request.
  assign forced_gnt = vid_req && ((cpu_ack && cpu_starved) || (dma_ack && dma_starved));

  always_ff @(posedge clock_50) begin
    if (res) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
      stat_cnt <= '0;
    end else begin
      if (vid_ack)    stat_q[0] <= stat_q[0] + 16'd1;
      if (cpu_ack)    stat_q[1] <= stat_q[1] + 16'd1;
      if (dma_ack)    stat_q[2] <= stat_q[2] + 16'd1;
      if (forced_gnt) stat_q[3] <= stat_q[3] + 16'd1;
      stat_cnt <= stat_q[stat_sel];
    end
  end
`endif

endmodule
